sc_mnist_classifier_win: RTL and testbench
==========================================

Name: sc_mnist_classifier_win

Overview:
- Windowed stochastic-computing MNIST classifier: the two-layer APC-neuron network plus output integration and class decision.
- Accepts one N0-bit input bitstream sample per handshake for WIN_LEN valid samples.
- Counts ones on each of the N2 output streams, then scans the counters sequentially for argmax.
- Reports the winning class with a done pulse. Sits between the bitstream generator (SNG) and the host/result register.

Parameters:
- N0, 64: input bitstream lanes (pixels).
- K1, 6: layer-1 APC width; 2^K1 >= N0.
- N1, 32: hidden neurons.
- K2, 5: layer-2 APC width; 2^K2 >= N1.
- N2, 10: output classes.
- WIN_LEN, 256: valid samples per classification window; >= 1.
- PIPE_LAT, 2: clock cycles from din accepted to the matching layer-2 output bit.
- CW, $clog2(WIN_LEN+1): class counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a window; sampled only in IDLE.
- din_valid  in  1  din carries a valid sample.
- din_ready  out  1  block accepts din this cycle.
- din  in  N0  input bitstream sample.
- weight_0  in  N1 x N0  layer-1 weight bitstreams.
- weight_1  in  N2 x N1  layer-2 weight bitstreams.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the result is valid.
- class_idx  out  $clog2(N2)  winning class; held until the next done.
- class_cnt  out  CW  ones-count of the winning class.

Behaviour:
- Reset (reset=0, async): FSM=IDLE; all counters 0; din_ready=0, busy=0, done=0, class_idx=0, class_cnt=0; neuron clear asserted.
- FSM states: IDLE -> CLR -> RUN -> DRAIN -> SCAN -> DONE -> IDLE.
- IDLE: start=1 -> CLR.
- CLR (1 cycle):
  - Registered neuron clear drives the sc_apc_neuron reset; the clear is high in IDLE and CLR only.
  - Zero the N2 class counters, sample counter and valid pipeline.
- RUN:
  - din_ready=1; a sample is accepted when din_valid&din_ready.
  - Accepted sample: registered din enters layer 1; valid bit enters the PIPE_LAT-deep valid shift register.
  - Non-accepted cycle: layer 1 is fed all-zeros; a 0 enters the valid pipe.
  - Sample counter increments per accepted sample. When the WIN_LEN-th sample is accepted: din_ready drops the next cycle, FSM -> DRAIN.
- Counting (RUN and DRAIN): when the valid pipe output is 1, cnt[j] += layer2_out[j] for every j. Counters saturate at WIN_LEN; saturation cannot occur in legal operation but must hold under assertion-disabled sims.
- DRAIN: PIPE_LAT cycles, then -> SCAN.
- SCAN:
  - Sequential argmax by sub-module, one class per cycle, N2 cycles.
  - Strictly-greater compare, so ties resolve to the lowest index.
  - -> DONE.
- DONE (1 cycle): register class_idx/class_cnt, done=1, -> IDLE.
- Total latency, start to done: 1 + (RUN cycles) + PIPE_LAT + N2 + 1.
- start outside IDLE is ignored.
- start and done in the same cycle: done is issued; start is ignored (FSM is in DONE).
- reset mid-window: immediate IDLE, partial counts discarded, previous class_idx cleared to 0.
- din_valid low for any number of cycles in RUN: window simply stretches; counts are unaffected.

Optional Feature:
- SC_MNIST_SCORES_EN.
- Defined: extra output port scores [N2] x CW carrying all class counters, registered at DONE and held until the next DONE. Reset value 0.
- Undefined: port absent; counters are internal only.

Decomposition:
- Package sc_mnist_pkg:
  - FSM state enum (IDLE, CLR, RUN, DRAIN, SCAN, DONE).
  - Default N0/N1/N2/K1/K2 constants.
  - Function clog2_min1, returning >= 1.
- Natural sub-module sc_argmax_seq:
  - Parameters N, W. Interface: start, vals [N] x W; outputs idx, max, done.
  - One compare per cycle, lowest-index tie-break.
- Layers reuse existing sc_apc_neuron instances (generate loops).

Test Plan:
- WIN_LEN=16, weights all-ones, din all-ones, din_valid constant 1 -> done exactly 1+16+2+10+1=30 cycles after start; every class count 16; class_idx=0 (tie -> lowest).
- weight_1 row 7 all-ones, other rows all-zeros, din all-ones -> class_idx=7, class_cnt=16, other scores 0 (SCORES_EN).
- din_valid toggling 1,0,1,0… -> din_ready high for 31 cycles; counts identical to the constant-valid run with the same accepted data.
- reset driven low at RUN sample 8, released, new start -> class_idx=0 during reset; the new window yields fresh counts with no residue.
- start pulsed during RUN and SCAN -> no restart; exactly one done per accepted start.
- WIN_LEN=1 boundary -> single accepted sample; class_cnt in {0,1}; done at cycle 1+1+2+10+1.

Source files
------------

// File: rtl/sc_mnist_pkg.sv
// Shared types and defaults for the windowed SC MNIST classifier.
// FSM encoding, default network sizes and a width helper.
package sc_mnist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RUN,
        DRAIN,
        SCAN,
        DONE
    } state_t;

    localparam int N0_DEF = 64;
    localparam int K1_DEF = 6;
    localparam int N1_DEF = 32;
    localparam int K2_DEF = 5;
    localparam int N2_DEF = 10;

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/sc_mnist_classifier_win_if.sv
// Input bitstream handshake between the SNG and the classifier.
// The SNG side is master; the classifier side is slave.
interface sc_mnist_classifier_win_if #(
    parameter int N0 = 64
);
    logic          din_valid;
    logic          din_ready;
    logic [N0-1:0] din;

    modport master (
        output din_valid,
        output din,
        input  din_ready
    );

    modport slave (
        input  din_valid,
        input  din,
        output din_ready
    );
endinterface

// File: rtl/sc_apc_neuron.sv
// APC neuron: AND-multiply input and weight streams, popcount,
// and emit 1 when more than half the products are 1.
module sc_apc_neuron #(
    parameter int N = 64,
    parameter int K = 6
) (
    input  logic         clr,
    input  logic [N-1:0] x,
    input  logic [N-1:0] w,
    output logic         y
);
    logic [K:0] pc;

    always_comb begin
        pc = '0;
        for (int i = 0; i < N; i++) begin
            pc = pc + (K+1)'(x[i] & w[i]);
        end
        y = !clr && ((2 * int'(pc)) > N);
    end
endmodule

// File: rtl/sc_argmax_seq.sv
// Sequential argmax, one compare per cycle over N values.
// Strictly-greater compare keeps the lowest index on ties.
module sc_argmax_seq
    import sc_mnist_pkg::*;
#(
    parameter int N  = 10,
    parameter int W  = 8,
    parameter int IW = clog2_min1(N)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [N-1:0][W-1:0] vals,
    output logic [IW-1:0]       idx,
    output logic [W-1:0]        max,
    output logic                done
);
    logic [IW-1:0] ptr;
    logic [IW-1:0] best_idx;
    logic [W-1:0]  best;
    logic          run;
    logic          gt;

    // Outputs include the compare in flight so the last one is visible.
    assign gt   = vals[ptr] > best;
    assign idx  = gt ? ptr : best_idx;
    assign max  = gt ? vals[ptr] : best;
    assign done = run && (ptr == IW'(N - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr      <= '0;
            best_idx <= '0;
            best     <= '0;
            run      <= 1'b0;
        end else if (start) begin
            ptr      <= '0;
            best_idx <= '0;
            best     <= '0;
            run      <= 1'b1;
        end else if (run) begin
            ptr      <= done ? '0 : ptr + 1'b1;
            best_idx <= idx;
            best     <= max;
            run      <= !done;
        end
    end
endmodule

// File: rtl/sc_mnist_classifier_win.sv
// Windowed SC MNIST classifier: two APC layers, class counters, argmax.
// Define SC_MNIST_SCORES_EN to expose all class counters on scores.
module sc_mnist_classifier_win
    import sc_mnist_pkg::*;
#(
    parameter int N0       = N0_DEF,
    parameter int K1       = K1_DEF,
    parameter int N1       = N1_DEF,
    parameter int K2       = K2_DEF,
    parameter int N2       = N2_DEF,
    parameter int WIN_LEN  = 256,
    parameter int PIPE_LAT = 2,
    parameter int CW       = $clog2(WIN_LEN + 1),
    localparam int IW      = clog2_min1(N2)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    sc_mnist_classifier_win_if.slave s_if,
    input  logic [N1-1:0][N0-1:0] weight_0,
    input  logic [N2-1:0][N1-1:0] weight_1,
    output logic                  busy,
    output logic                  done,
    output logic [IW-1:0]         class_idx,
    output logic [CW-1:0]         class_cnt
`ifdef SC_MNIST_SCORES_EN
    ,
    output logic [N2-1:0][CW-1:0] scores
`endif
);
    localparam int DW = clog2_min1(PIPE_LAT);

    state_t                state;
    state_t                state_nx;
    logic                  acc;
    logic                  last;
    logic                  drain_last;
    logic                  nclr;
    logic [N0-1:0]         din_reg;
    logic [N1-1:0]         hid;
    logic [N1-1:0]         hid_q;
    logic [N2-1:0]         outb;
    logic [PIPE_LAT-1:0]   vpipe;
    logic [CW-1:0]         sample_cnt;
    logic [DW-1:0]         drain_cnt;
    logic [N2-1:0][CW-1:0] cnt;
    logic                  am_start;
    logic                  am_done;
    logic [IW-1:0]         am_idx;
    logic [CW-1:0]         am_max;

    assign s_if.din_ready = (state == RUN);
    assign busy       = (state != IDLE);
    assign acc        = s_if.din_valid && s_if.din_ready;
    assign last       = acc && (sample_cnt == CW'(WIN_LEN - 1));
    assign drain_last = (drain_cnt == DW'(PIPE_LAT - 1));
    assign am_start   = (state == DRAIN) && drain_last;

    for (genvar i = 0; i < N1; i++) begin : g_l1
        sc_apc_neuron #(.N(N0), .K(K1)) u_n (
            .clr (nclr),
            .x   (din_reg),
            .w   (weight_0[i]),
            .y   (hid[i])
        );
    end

    for (genvar j = 0; j < N2; j++) begin : g_l2
        sc_apc_neuron #(.N(N1), .K(K2)) u_n (
            .clr (nclr),
            .x   (hid_q),
            .w   (weight_1[j]),
            .y   (outb[j])
        );
    end

    sc_argmax_seq #(.N(N2), .W(CW), .IW(IW)) u_argmax (
        .clk   (clk),
        .reset (reset),
        .start (am_start),
        .vals  (cnt),
        .idx   (am_idx),
        .max   (am_max),
        .done  (am_done)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = CLR;
            CLR:     state_nx = RUN;
            RUN:     if (last) state_nx = DRAIN;
            DRAIN:   if (drain_last) state_nx = SCAN;
            SCAN:    if (am_done) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nclr       <= 1'b1;
            din_reg    <= '0;
            hid_q      <= '0;
            vpipe      <= '0;
            sample_cnt <= '0;
            drain_cnt  <= '0;
            cnt        <= '0;
            done       <= 1'b0;
            class_idx  <= '0;
            class_cnt  <= '0;
`ifdef SC_MNIST_SCORES_EN
            scores     <= '0;
`endif
        end else begin
            nclr    <= (state_nx == IDLE) || (state_nx == CLR);
            din_reg <= acc ? s_if.din : '0;
            hid_q   <= nclr ? '0 : hid;
            if (state == CLR) begin
                vpipe      <= '0;
                sample_cnt <= '0;
                drain_cnt  <= '0;
                cnt        <= '0;
            end else begin
                vpipe <= (vpipe << 1) | PIPE_LAT'(acc);
                if (acc) sample_cnt <= sample_cnt + 1'b1;
                if (state == DRAIN)
                    drain_cnt <= drain_last ? '0 : drain_cnt + 1'b1;
                // Saturation guards against illegal over-long windows.
                if ((state == RUN || state == DRAIN) && vpipe[PIPE_LAT-1]) begin
                    for (int j = 0; j < N2; j++) begin
                        if (cnt[j] != CW'(WIN_LEN))
                            cnt[j] <= cnt[j] + CW'(outb[j]);
                    end
                end
            end
            done <= (state == SCAN) && am_done;
            if ((state == SCAN) && am_done) begin
                class_idx <= am_idx;
                class_cnt <= am_max;
`ifdef SC_MNIST_SCORES_EN
                scores    <= cnt;
`endif
            end
        end
    end
endmodule

// File: tb/tb_sc_mnist_classifier_win.sv
// Scoreboard bench: WIN_LEN=16 and WIN_LEN=1 instances.
// Drivers push expected results; negedge monitors pop and compare.
module tb_sc_mnist_classifier_win;
    import sc_mnist_pkg::*;

    localparam int N0   = 64;
    localparam int N1   = 32;
    localparam int N2   = 10;
    localparam int WL   = 16;
    localparam int CW16 = $clog2(WL + 1);
    localparam int CW1  = 1;

    typedef struct {
        int            idx;
        int            cnt;
        int            lat;
        logic [N2-1:0] mask;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst16, rst1, start16, start1;
    logic [N1-1:0][N0-1:0] w0;
    logic [N2-1:0][N1-1:0] w1_16, w1_1;
    logic                  busy16, done16, busy1, done1;
    logic [3:0]            idx16, idx1;
    logic [CW16-1:0]       cnt16;
    logic [CW1-1:0]        cnt1;
`ifdef SC_MNIST_SCORES_EN
    logic [N2-1:0][CW16-1:0] scores16;
    logic [N2-1:0][CW1-1:0]  scores1;
`endif

    sc_mnist_classifier_win_if #(.N0(N0)) if16 ();
    sc_mnist_classifier_win_if #(.N0(N0)) if1 ();

    sc_mnist_classifier_win #(
        .N0(N0), .K1(6), .N1(N1), .K2(5), .N2(N2), .WIN_LEN(WL), .PIPE_LAT(2)
    ) dut16 (
        .clk       (clk),
        .reset     (rst16),
        .start     (start16),
        .s_if      (if16),
        .weight_0  (w0),
        .weight_1  (w1_16),
        .busy      (busy16),
        .done      (done16),
        .class_idx (idx16),
        .class_cnt (cnt16)
`ifdef SC_MNIST_SCORES_EN
        ,
        .scores    (scores16)
`endif
    );

    sc_mnist_classifier_win #(
        .N0(N0), .K1(6), .N1(N1), .K2(5), .N2(N2), .WIN_LEN(1), .PIPE_LAT(2)
    ) dut1 (
        .clk       (clk),
        .reset     (rst1),
        .start     (start1),
        .s_if      (if1),
        .weight_0  (w0),
        .weight_1  (w1_1),
        .busy      (busy1),
        .done      (done1),
        .class_idx (idx1),
        .class_cnt (cnt1)
`ifdef SC_MNIST_SCORES_EN
        ,
        .scores    (scores1)
`endif
    );

    exp_t q16[$];
    exp_t q1[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int st16 = 0;
    int st1 = 0;
    int nd16 = 0;
    int nd1 = 0;
    int push16 = 0;
    int push1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    always @(negedge clk) begin : mon16
        exp_t e;
        if (rst16 && done16) begin
            nd16++;
            if (q16.size() == 0) begin
                chk("unexpected_done16", 1, 0);
            end else begin
                e = q16.pop_front();
                chk("class_idx16", int'(idx16), e.idx);
                chk("class_cnt16", int'(cnt16), e.cnt);
                chk("latency16", cyc - st16, e.lat);
`ifdef SC_MNIST_SCORES_EN
                for (int j = 0; j < N2; j++)
                    chk("scores16", int'(scores16[j]), e.mask[j] ? e.cnt : 0);
`endif
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst1 && done1) begin
            nd1++;
            if (q1.size() == 0) begin
                chk("unexpected_done1", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("class_idx1", int'(idx1), e.idx);
                chk("class_cnt1", int'(cnt1), e.cnt);
                chk("latency1", cyc - st1, e.lat);
`ifdef SC_MNIST_SCORES_EN
                for (int j = 0; j < N2; j++)
                    chk("scores1", int'(scores1[j]), e.mask[j] ? e.cnt : 0);
`endif
            end
        end
    end

    task automatic run16(
        input int            n_ones,
        input bit            tog,
        input bit            xstart,
        input int            abort_at,
        input int            eidx,
        input int            ecnt,
        input int            elat,
        input logic [N2-1:0] mask,
        input int            erdy
    );
        int acc = 0;
        int rdy_n = 0;
        int guard = 0;
        bit ph = 1'b1;
        bit v;
        exp_t e;
        @(negedge clk);
        start16 = 1'b1;
        st16 = cyc;
        if (abort_at < 0) begin
            e.idx = eidx; e.cnt = ecnt; e.lat = elat; e.mask = mask;
            q16.push_back(e);
            push16++;
        end
        @(negedge clk);
        start16 = 1'b0;
        while (acc < WL && guard < 200) begin
            if (abort_at >= 0 && acc == abort_at) break;
            if (if16.din_ready) begin
                rdy_n++;
                v = tog ? ph : 1'b1;
                ph = ~ph;
            end else begin
                v = 1'b0;
            end
            if16.din_valid = v;
            if16.din = (v && acc >= n_ones) ? '0 : '1;
            start16 = xstart && (acc == 5);
            if (v) acc++;
            guard++;
            @(negedge clk);
        end
        if16.din_valid = 1'b0;
        start16 = 1'b0;
        if (abort_at >= 0) begin
            rst16 = 1'b0;
            @(negedge clk);
            chk("abort_class_idx", int'(idx16), 0);
            chk("abort_busy", int'(busy16), 0);
            chk("abort_ready", int'(if16.din_ready), 0);
            rst16 = 1'b1;
            @(negedge clk);
            return;
        end
        for (int i = 0; i < 6; i++) begin
            if (if16.din_ready) rdy_n++;
            start16 = xstart && (i == 4);
            @(negedge clk);
        end
        start16 = 1'b0;
        chk("ready_cycles", rdy_n, erdy);
        guard = 0;
        while (nd16 < push16 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("done16_count", nd16, push16);
        @(negedge clk);
        chk("busy_after_done", int'(busy16), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        exp_t e;
        rst16 = 1'b0; rst1 = 1'b0;
        start16 = 1'b0; start1 = 1'b0;
        if16.din_valid = 1'b0; if16.din = '0;
        if1.din_valid = 1'b0; if1.din = '0;
        w0 = '1; w1_16 = '1; w1_1 = '1;
        repeat (3) @(negedge clk);
        chk("rst_done", int'(done16), 0);
        chk("rst_busy", int'(busy16), 0);
        chk("rst_idx", int'(idx16), 0);
        chk("rst_cnt", int'(cnt16), 0);
        chk("rst_ready", int'(if16.din_ready), 0);
        rst16 = 1'b1; rst1 = 1'b1;
        repeat (2) @(negedge clk);

        run16(16, 1'b0, 1'b0, -1, 0, 16, 30, '1, 16);
        w1_16 = '0; w1_16[7] = '1;
        run16(16, 1'b0, 1'b0, -1, 7, 16, 30, 10'b0010000000, 16);
        w1_16 = '1;
        run16(16, 1'b1, 1'b0, -1, 0, 16, 45, '1, 31);
        w1_16 = '0; w1_16[2] = '1; w1_16[5] = '1;
        run16(10, 1'b0, 1'b0, -1, 2, 10, 30, 10'b0000100100, 16);
        w1_16 = '0; w1_16[4] = '1;
        run16(16, 1'b0, 1'b1, -1, 4, 16, 30, 10'b0000010000, 16);
        w1_16 = '1;
        run16(16, 1'b0, 1'b0, 8, 0, 0, 0, '0, 0);
        run16(0, 1'b0, 1'b0, -1, 0, 0, 30, '1, 16);

        @(negedge clk);
        start1 = 1'b1;
        st1 = cyc;
        e.idx = 0; e.cnt = 1; e.lat = 15; e.mask = '1;
        q1.push_back(e);
        push1++;
        @(negedge clk);
        start1 = 1'b0;
        if1.din_valid = 1'b1;
        if1.din = '1;
        guard = 0;
        while (nd1 < push1 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if1.din_valid = 1'b0;
        chk("done1_count", nd1, push1);

        repeat (40) @(negedge clk);
        chk("final_done16", nd16, push16);
        chk("final_q16", q16.size(), 0);
        chk("final_done1", nd1, push1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
